// File: rtl/sgd_x_rmw_pipe_pkg.sv
// rtl/sgd_x_rmw_pipe_pkg.sv - package sgd_pkg: lane width, lane word type, read-latency limit, word-count helper
package sgd_pkg;

    localparam int LANE_W         = 32;
    localparam int MAX_RD_LATENCY = 4;

    typedef logic signed [LANE_W-1:0] lane_t;

    // Words needed to cover dim elements when each word holds 2**shift elements.
    function automatic logic [31:0] words_for(input logic [31:0] dim, input int shift);
        logic [31:0] low_mask;
        low_mask  = (32'd1 << shift) - 32'd1;
        words_for = (dim >> shift) + {31'd0, |(dim & low_mask)};
    endfunction

endpackage

// File: rtl/sgd_x_rmw_pipe_if.sv
// rtl/sgd_x_rmw_pipe_if.sv - x memory read/write port bundle for the x read-modify-write pipe
interface sgd_x_rmw_pipe_if #(
    parameter int NUM_LANES  = 8,
    parameter int ADDR_WIDTH = 10
);
    import sgd_pkg::*;

    logic [ADDR_WIDTH-1:0]       rd_addr;
    logic [NUM_LANES*LANE_W-1:0] rd_data;
    logic                        wr_en;
    logic [ADDR_WIDTH-1:0]       wr_addr;
    logic [NUM_LANES*LANE_W-1:0] wr_data;

    modport master (
        output rd_addr,
        input  rd_data,
        output wr_en,
        output wr_addr,
        output wr_data
    );

    modport slave (
        input  rd_addr,
        output rd_data,
        input  wr_en,
        input  wr_addr,
        input  wr_data
    );

endinterface

// File: rtl/sgd_x_rmw_pipe_lane_sub.sv
// rtl/sgd_x_rmw_pipe_lane_sub.sv - sgd_lane_sub: one lane of x - grad; saturating when SGD_X_SAT_EN is defined
module sgd_lane_sub
    import sgd_pkg::*;
(
    input  lane_t x_i,
    input  lane_t g_i,
    output lane_t y_o
);

`ifdef SGD_X_SAT_EN
    logic signed [LANE_W:0] diff;

    // One guard bit: overflow shows as the top two bits disagreeing.
    always_comb begin
        diff = {x_i[LANE_W-1], x_i} - {g_i[LANE_W-1], g_i};
        if (diff[LANE_W] != diff[LANE_W-1]) begin
            y_o = diff[LANE_W] ? {1'b1, {(LANE_W-1){1'b0}}} : {1'b0, {(LANE_W-1){1'b1}}};
        end else begin
            y_o = diff[LANE_W-1:0];
        end
    end
`else
    assign y_o = x_i - g_i;
`endif

endmodule

// File: rtl/sgd_x_rmw_pipe.sv
// rtl/sgd_x_rmw_pipe.sv - SGD x-vector read-modify-write pipe with write forwarding; SGD_X_SAT_EN selects saturating lanes
module sgd_x_rmw_pipe
    import sgd_pkg::*;
#(
    parameter int NUM_LANES  = 8,
    parameter int ADDR_WIDTH = 10,
    parameter int RD_LATENCY = 2,
    parameter int WORD_SHIFT = 6
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        started,
    input  logic [31:0]                 dimension,
    input  logic                        grad_valid,
    input  logic [NUM_LANES*LANE_W-1:0] grad,
    sgd_x_rmw_pipe_if.master            mem,
    output logic                        pass_done,
    output logic                        fwd_hit
);

    localparam int W = NUM_LANES * LANE_W;
    localparam int L = RD_LATENCY + 1;

    typedef logic [W-1:0]          word_t;
    typedef logic [ADDR_WIDTH-1:0] addr_t;

    if (RD_LATENCY < 1 || RD_LATENCY > MAX_RD_LATENCY) begin : g_bad_latency
        $error("sgd_x_rmw_pipe: RD_LATENCY out of range");
    end

    logic [31:0]           num_words_q;
    addr_t                 last_addr_q;
    addr_t                 rd_addr_q, rd_addr_d;
    logic                  accept;

    logic [RD_LATENCY-1:0] dv_q;
    addr_t                 da_q [RD_LATENCY];
    word_t                 dg_q [RD_LATENCY];

    // Write history: entry 0 is the live write port, older writes follow.
    logic [L-1:0]          hv_q;
    addr_t                 ha_q [L];
    word_t                 hd_q [L];

    word_t                 x_old, x_new;
    logic                  hit;
    logic                  pass_done_q, fwd_hit_q;

    always_ff @(posedge clk) begin
        num_words_q <= words_for(dimension, WORD_SHIFT);
        last_addr_q <= addr_t'(num_words_q - 32'd1);
    end

    assign accept = grad_valid && started;

    always_comb begin
        rd_addr_d = rd_addr_q;
        if (!started) begin
            rd_addr_d = '0;
        end else if (grad_valid) begin
            rd_addr_d = (rd_addr_q == last_addr_q) ? '0 : rd_addr_q + addr_t'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_addr_q <= '0;
        end else begin
            rd_addr_q <= rd_addr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            dv_q <= '0;
        end else begin
            dv_q[0] <= accept;
            for (int k = 1; k < RD_LATENCY; k++) begin
                dv_q[k] <= dv_q[k-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        da_q[0] <= rd_addr_q;
        dg_q[0] <= grad;
        for (int k = 1; k < RD_LATENCY; k++) begin
            da_q[k] <= da_q[k-1];
            dg_q[k] <= dg_q[k-1];
        end
    end

    // Scan oldest to youngest so the most recent matching write wins.
    always_comb begin
        x_old = mem.rd_data;
        hit   = 1'b0;
        for (int j = L - 1; j >= 0; j--) begin
            if (hv_q[j] && (ha_q[j] == da_q[RD_LATENCY-1])) begin
                x_old = hd_q[j];
                hit   = 1'b1;
            end
        end
    end

    for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
        sgd_lane_sub u_sub (
            .x_i (x_old[i*LANE_W +: LANE_W]),
            .g_i (dg_q[RD_LATENCY-1][i*LANE_W +: LANE_W]),
            .y_o (x_new[i*LANE_W +: LANE_W])
        );
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hv_q        <= '0;
            pass_done_q <= 1'b0;
            fwd_hit_q   <= 1'b0;
            for (int j = 0; j < L; j++) begin
                ha_q[j] <= '0;
                hd_q[j] <= '0;
            end
        end else begin
            hv_q[0] <= dv_q[RD_LATENCY-1];
            if (dv_q[RD_LATENCY-1]) begin
                ha_q[0] <= da_q[RD_LATENCY-1];
                hd_q[0] <= x_new;
            end
            for (int j = 1; j < L; j++) begin
                hv_q[j] <= hv_q[j-1];
                ha_q[j] <= ha_q[j-1];
                hd_q[j] <= hd_q[j-1];
            end
            pass_done_q <= dv_q[RD_LATENCY-1] && (da_q[RD_LATENCY-1] == last_addr_q);
            fwd_hit_q   <= dv_q[RD_LATENCY-1] && hit;
        end
    end

    assign mem.rd_addr = rd_addr_q;
    assign mem.wr_en   = hv_q[0];
    assign mem.wr_addr = ha_q[0];
    assign mem.wr_data = hd_q[0];
    assign pass_done   = pass_done_q;
    assign fwd_hit     = fwd_hit_q;

endmodule
